sdram_traffic_chk: RTL and testbench
====================================

Name: sdram_traffic_chk

Overview:
Single-clock traffic generator and checker attached to the user side of the SDRAM top level. It pushes a deterministic word stream into the write-FIFO port (wen/din), then reads the stream back through the read-FIFO port (ren/dout) and compares every word. It is used for board bring-up and regression of the SDRAM path, with w_clk and r_clk both driven from sysclk_100M. Pass/fail, error count and first-failing index are reported on status outputs.

Parameters:
TOTAL_WORDS, 1024, number of words written, and then checked, per run (≥1).
RD_LAT, 1, cycles from ren asserted to valid dout (1..4).
SEED, 16'h0001, LFSR seed; a value of 0 is replaced by 16'h0001.
TIMEOUT, 65535, idle cycles without read progress before the run aborts.
CW, $clog2(TOTAL_WORDS+1), counter width (derived).

Ports:
sysclk_100M  in  1  system clock; all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that starts a run; ignored while busy.
mode  in  1  0 = incrementing pattern, 1 = LFSR pattern; sampled on start.
wfifo_full  in  1  write FIFO full.
wen  out  1  write-FIFO push.
din  out  16  write data.
rfifo_empty  in  1  read FIFO empty.
ren  out  1  read-FIFO pop.
dout  in  16  read data, valid RD_LAT cycles after ren.
busy  out  1  run in progress.
done  out  1  run finished; held until the next start.
pass  out  1  done with err_cnt==0 and no timeout; held with done.
timeout  out  1  run aborted by TIMEOUT; held with done.
err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
first_err_idx  out  CW  index of the first mismatching word.
wr_cnt  out  CW  words pushed.
rd_cnt  out  CW  words compared.

Behaviour:
- Reset: every output is 0. The FSM enters IDLE and both pattern generators load their seed.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: on start, latch mode; clear the counters, err_cnt, first_err_idx and the done/pass/timeout flags; go to RUN. busy=1 from the next cycle.
  - RUN: the writer and checker run concurrently. Go to FLUSH when rd_issued==TOTAL_WORDS. Go to DONE with timeout=1 if the idle counter reaches TIMEOUT.
  - FLUSH: wait RD_LAT cycles for in-flight reads, then go to DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0 && !timeout). A start pulse returns the FSM to RUN with a fresh run.
- Writer:
  - wen = RUN && !wfifo_full && wr_cnt<TOTAL_WORDS. This is combinational, so a word is never pushed into a full FIFO.
  - din = gen pattern register (registered).
  - On each push: wr_cnt++ and the generator advances.
- Checker:
  - ren = RUN && !rfifo_empty && rd_issued<TOTAL_WORDS (combinational).
  - A RD_LAT-deep valid shift register tracks issued reads.
  - When a read's valid bit exits the shift register: compare dout with the check-pattern register, advance the checker, rd_cnt++.
  - On mismatch: err_cnt++ (saturating). If err_cnt was 0, first_err_idx = rd_cnt (pre-increment value).
- Patterns:
  - mode 0: word k = k[15:0], wrapping at 65536.
  - mode 1: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0. Word 0 = SEED, advancing one step per word.
- Timeout: the idle counter resets on every compare and every push, and increments otherwise while in RUN.
- Simultaneous push and pop in one cycle are independent and both allowed. A start pulse in the same cycle as a FIFO status change gives no special case.
- Reset mid-run: everything returns to reset values immediately. No partial status is retained.

Decomposition:
- Package sdram_tc_pkg:
  - mode encodings MODE_INC=1'b0, MODE_LFSR=1'b1
  - LFSR tap mask 16'hB400
  - FSM state enum
  - default seed
- Sub-module sdram_tc_pattern: load/advance/mode inputs and a 16-bit value output. It is instantiated twice, once for the writer and once for the checker, so both produce identical sequences.

Test Plan:
1. Loopback model (FIFO depth 512, RD_LAT=1), mode 0, start → din 0..1023 pushed in order; done=1, pass=1, err_cnt=0, wr_cnt=rd_cnt=1024.
2. mode 1, SEED=16'hACE1 → first three din are 16'hACE1, then two LFSR steps matching a reference model; pass=1.
3. Loopback corrupts word 37 (bit 0 flipped) and word 600 → err_cnt=2, first_err_idx=37, pass=0, done=1.
4. wfifo_full held for 100 cycles in mid-run and rfifo_empty toggled randomly → no wen while full, every word is still checked once, pass=1.
5. Read path stalled (rfifo_empty=1 permanently), TIMEOUT=200 → after 200 idle cycles done=1, timeout=1, pass=0; start during busy is ignored.
6. rst_n low at word 500, then a new start → all status returns to 0, and the rerun passes with first din=0.

Source files
------------

// File: rtl/sdram_tc_pkg.sv
// Shared types and constants for the SDRAM traffic generator/checker.
// Holds the pattern mode encodings, LFSR taps, default seed and FSM states.
package sdram_tc_pkg;

    localparam logic        MODE_INC     = 1'b0;
    localparam logic        MODE_LFSR    = 1'b1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    function automatic logic [15:0] eff_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? DEFAULT_SEED : seed;
    endfunction

    // x^16+x^14+x^13+x^11+1, shifted left with the feedback entering bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sdram_tc_pattern.sv
// Pattern generator shared by writer and checker: incrementing count or LFSR.
// Both instances see the same load/mode sequence, so they emit identical streams.
module sdram_tc_pattern
    import sdram_tc_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic        mode_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = (mode_i == MODE_LFSR) ? eff_seed(SEED) : 16'h0000;
        end else if (advance_i) begin
            value_d = (mode_i == MODE_LFSR) ? lfsr_step(value_q) : value_q + 16'd1;
        end
    end

    // Reset state is the incrementing-mode start value, which keeps din at 0 out of reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 16'h0000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/sdram_traffic_chk.sv
// SDRAM user-side traffic generator and checker: writes a deterministic stream
// into the write FIFO, reads it back through the read FIFO and compares every word.
module sdram_traffic_chk
    import sdram_tc_pkg::*;
#(
    parameter int          TOTAL_WORDS = 1024,
    parameter int          RD_LAT      = 1,
    parameter logic [15:0] SEED        = DEFAULT_SEED,
    parameter int          TIMEOUT     = 65535,
    localparam int         CW          = $clog2(TOTAL_WORDS + 1)
) (
    input  logic          sysclk_100M,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic          wfifo_full,
    output logic          wen,
    output logic [15:0]   din,
    input  logic          rfifo_empty,
    output logic          ren,
    input  logic [15:0]   dout,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_cnt,
    output logic [CW-1:0] first_err_idx,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt
);

    localparam int            IW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TOTAL_CW   = CW'(TOTAL_WORDS);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
    localparam logic [2:0]    FLUSH_LAST = 3'(RD_LAT - 1);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]       rd_issued_q, rd_issued_d;
    logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [CW-1:0]       first_err_q, first_err_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic [2:0]          flush_q, flush_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    logic                run;
    logic                start_acc;
    logic                cmp_vld;
    logic                mismatch;
    logic                pat_mode;
    logic [15:0]         gen_value;
    logic [15:0]         chk_value;

    assign run       = (state_q == ST_RUN);
    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign wen       = run && !wfifo_full  && (wr_cnt_q    < TOTAL_CW);
    assign ren       = run && !rfifo_empty && (rd_issued_q < TOTAL_CW);
    assign cmp_vld   = vld_q[RD_LAT-1];
    assign mismatch  = cmp_vld && (dout != chk_value);

    // Generators load with the freshly sampled mode in the start cycle.
    assign pat_mode  = start_acc ? mode : mode_q;

    sdram_tc_pattern #(
        .SEED (SEED)
    ) u_gen (
        .clk       (sysclk_100M),
        .rst_n     (rst_n),
        .load_i    (start_acc),
        .advance_i (wen),
        .mode_i    (pat_mode),
        .value_o   (gen_value)
    );

    sdram_tc_pattern #(
        .SEED (SEED)
    ) u_chk (
        .clk       (sysclk_100M),
        .rst_n     (rst_n),
        .load_i    (start_acc),
        .advance_i (cmp_vld),
        .mode_i    (pat_mode),
        .value_o   (chk_value)
    );

    // Valid bit of each issued read; it reaches the top when dout carries that word.
    always_comb begin
        vld_d = vld_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
        end
        vld_d[0] = ren;
        if (start_acc) begin
            vld_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_cnt_d    = wr_cnt_q;
        rd_issued_d = rd_issued_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        idle_d      = idle_q;
        flush_d     = flush_q;
        done_d      = done_q;
        timeout_d   = timeout_q;

        if (wen) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (ren) begin
            rd_issued_d = rd_issued_q + CW'(1);
        end
        if (cmp_vld) begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            if (mismatch) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
                if (err_cnt_q == 16'h0000) begin
                    first_err_d = rd_cnt_q;
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    mode_d      = mode;
                    wr_cnt_d    = '0;
                    rd_issued_d = '0;
                    rd_cnt_d    = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    idle_d      = '0;
                    flush_d     = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_RUN: begin
                flush_d = '0;
                idle_d  = (wen || cmp_vld) ? '0 : idle_q + IW'(1);
                if (rd_issued_q == TOTAL_CW) begin
                    state_d = ST_FLUSH;
                end else if (!wen && !cmp_vld && (idle_q == IDLE_LAST)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_INC;
            wr_cnt_q    <= '0;
            rd_issued_q <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            idle_q      <= '0;
            flush_q     <= '0;
            vld_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_issued_q <= rd_issued_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            idle_q      <= idle_d;
            flush_q     <= flush_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign din           = gen_value;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign pass          = done_q && (err_cnt_q == 16'h0000) && !timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
    assign wr_cnt        = wr_cnt_q;
    assign rd_cnt        = rd_cnt_q;

endmodule

// File: tb/tb_sdram_traffic_chk.sv
// Bench for sdram_traffic_chk: loopback FIFO model (depth 512, one-cycle read
// latency) with an independent pattern reference, table-driven runs and corner sequences.
module tb_sdram_traffic_chk;

    localparam int          TOTAL = 1024;
    localparam int          DEPTH = 512;
    localparam int          CW    = $clog2(TOTAL + 1);
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          TOUT  = 200;

    logic          clk = 1'b0;
    logic          rst_n, start, mode, wfifo_full, rfifo_empty;
    logic          wen, ren, busy, done, pass, timeout;
    logic [15:0]   din, dout, err_cnt;
    logic [CW-1:0] first_err_idx, wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    sdram_traffic_chk #(
        .TOTAL_WORDS (TOTAL),
        .RD_LAT      (1),
        .SEED        (SEED),
        .TIMEOUT     (TOUT)
    ) dut (
        .sysclk_100M   (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .wfifo_full    (wfifo_full),
        .wen           (wen),
        .din           (din),
        .rfifo_empty   (rfifo_empty),
        .ren           (ren),
        .dout          (dout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .wr_cnt        (wr_cnt),
        .rd_cnt        (rd_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference/loopback model state
    logic [15:0] fifo_q[$];
    logic [15:0] lfsr_tab[TOTAL];
    logic [15:0] pushed[TOTAL];
    int          wr_idx, pop_idx, din_bad, full_push, cor_a, cor_b;
    logic        cur_mode, force_full, force_empty, rand_en;

    typedef struct {
        logic mode;
        int   cor_a;
        int   cor_b;
        logic stall_full;
        logic rand_empty;
        int   exp_err;
        int   exp_first;
        logic exp_pass;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic m, input int k);
        if (m) return lfsr_tab[k];
        return 16'(k);
    endfunction

    // Loopback FIFO: decisions sampled at negedge, applied just after the rising edge.
    initial begin : model
        logic        do_push, do_pop;
        logic [15:0] wdata, v;
        forever begin
            @(negedge clk);
            do_push = rst_n && wen;
            do_pop  = rst_n && ren;
            wdata   = din;
            if (do_push) begin
                if (wfifo_full) full_push++;
                if (wr_idx < TOTAL) begin
                    pushed[wr_idx] = din;
                    if (din !== exp_word(cur_mode, wr_idx)) din_bad++;
                end
                wr_idx++;
            end
            @(posedge clk);
            #1;
            if (do_push) fifo_q.push_back(wdata);
            if (do_pop && fifo_q.size() > 0) begin
                v = fifo_q.pop_front();
                if (pop_idx == cor_a || pop_idx == cor_b) v ^= 16'h0001;
                dout = v;
                pop_idx++;
            end
            #1;
            wfifo_full  = (fifo_q.size() >= DEPTH) || force_full;
            rfifo_empty = (fifo_q.size() == 0) || force_empty || (rand_en && $urandom_range(0, 1) == 1);
        end
    end

    task automatic model_clear(input logic m);
        cur_mode = m;   cor_a = -1;     cor_b = -1;
        rand_en = 1'b0; force_full = 1'b0; force_empty = 1'b0;
        wr_idx = 0; pop_idx = 0; din_bad = 0; full_push = 0;
        fifo_q.delete();
    endtask

    task automatic pulse_start(input logic m);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        mode = m;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},   32'(wen),           32'd0);
        check({tag, "_ren"},   32'(ren),           32'd0);
        check({tag, "_din"},   32'(din),           32'd0);
        check({tag, "_busy"},  32'(busy),          32'd0);
        check({tag, "_done"},  32'(done),          32'd0);
        check({tag, "_pass"},  32'(pass),          32'd0);
        check({tag, "_tout"},  32'(timeout),       32'd0);
        check({tag, "_err"},   32'(err_cnt),       32'd0);
        check({tag, "_first"}, 32'(first_err_idx), 32'd0);
        check({tag, "_wrcnt"}, 32'(wr_cnt),        32'd0);
        check({tag, "_rdcnt"}, 32'(rd_cnt),        32'd0);
    endtask

    task automatic do_run(input vec_t v, input int id);
        logic  got;
        string t;
        t = $sformatf("run%0d", id);
        model_clear(v.mode);
        cor_a   = v.cor_a;
        cor_b   = v.cor_b;
        rand_en = v.rand_empty;
        pulse_start(v.mode);
        got = 1'b0;
        for (int c = 0; c < 8000 && !got; c++) begin
            @(negedge clk);
            if (c == 0) check({t, "_busy_after_start"}, 32'(busy), 32'd1);
            if (v.stall_full && c == 300) force_full = 1'b1;
            if (v.stall_full && c == 400) force_full = 1'b0;
            got = done;
        end
        check({t, "_done_seen"}, 32'(got),           32'd1);
        check({t, "_pass"},      32'(pass),          32'(v.exp_pass));
        check({t, "_timeout"},   32'(timeout),       32'd0);
        check({t, "_busy"},      32'(busy),          32'd0);
        check({t, "_err_cnt"},   32'(err_cnt),       32'(v.exp_err));
        check({t, "_first_err"}, 32'(first_err_idx), 32'(v.exp_first));
        check({t, "_wr_cnt"},    32'(wr_cnt),        32'(TOTAL));
        check({t, "_rd_cnt"},    32'(rd_cnt),        32'(TOTAL));
        check({t, "_pops"},      32'(pop_idx),       32'(TOTAL));
        check({t, "_din_bad"},   32'(din_bad),       32'd0);
        check({t, "_push_full"}, 32'(full_push),     32'd0);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s_din%0d", t, k), 32'(pushed[k]), 32'(exp_word(v.mode, k)));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] s;
        int last_w, done_c;

        s = SEED;
        for (int k = 0; k < TOTAL; k++) begin
            lfsr_tab[k] = s;
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end

        //          mode  cor_a cor_b stall rand  err first pass
        vecs[0] = '{1'b0, -1,   -1,   1'b0, 1'b0, 0,  0,    1'b1};
        vecs[1] = '{1'b1, -1,   -1,   1'b0, 1'b0, 0,  0,    1'b1};
        vecs[2] = '{1'b0, 37,   600,  1'b0, 1'b0, 2,  37,   1'b0};
        vecs[3] = '{1'b0, -1,   -1,   1'b1, 1'b1, 0,  0,    1'b1};
        vecs[4] = '{1'b1, 0,    1023, 1'b0, 1'b0, 2,  0,    1'b0};
        vecs[5] = '{1'b1, -1,   -1,   1'b1, 1'b1, 0,  0,    1'b1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; dout = 16'h0000;
        wfifo_full = 1'b0; rfifo_empty = 1'b1;
        model_clear(1'b0);
        #22;
        check_reset_outputs("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_run(vecs[i], i);

        // Read path stalled: timeout after TOUT idle cycles; a start while busy is ignored.
        model_clear(1'b0);
        force_empty = 1'b1;
        pulse_start(1'b0);
        last_w = -1;
        done_c = -1;
        for (int c = 0; c < 3000 && done_c < 0; c++) begin
            @(negedge clk);
            if (wen) last_w = c;
            if (done) done_c = c;
            if (c == 50) start = 1'b1;
            if (c == 51) start = 1'b0;
            if (c == 53) check("to_busy_after_restart_try", 32'(busy), 32'd1);
        end
        check("to_done_seen",  32'(done_c >= 0),     32'd1);
        check("to_idle_span",  32'(done_c - last_w), 32'(TOUT + 1));
        check("to_timeout",    32'(timeout),         32'd1);
        check("to_pass",       32'(pass),            32'd0);
        check("to_busy",       32'(busy),            32'd0);
        check("to_wr_cnt",     32'(wr_cnt),          32'(DEPTH));
        check("to_rd_cnt",     32'(rd_cnt),          32'd0);
        check("to_err_cnt",    32'(err_cnt),         32'd0);
        check("to_din_bad",    32'(din_bad),         32'd0);
        check("to_push_full",  32'(full_push),       32'd0);
        force_empty = 1'b0;

        // Reset in the middle of a run, then a clean rerun.
        model_clear(1'b0);
        pulse_start(1'b0);
        for (int c = 0; c < 3000 && wr_idx < 500; c++) @(negedge clk);
        check("mid_reached_500", 32'(wr_idx >= 500), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        do_run(vecs[0], 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
